// File: rtl/mux_scan_sequencer_pkg.sv
// Shared definitions for the mux scan sequencer.
// Holds the FSM state encoding, the scan length and the select/step widths,
// plus a helper that returns the select code a scan starts from.
package mux_scan_sequencer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int SCAN_LEN = 8;  // one step per mux input
  localparam int SEL_W    = 3;  // select code width, {s2,s1,s0}
  localparam int STEP_W   = 4;  // step count 0..SCAN_LEN

  // Counting up starts from input 0, counting down starts from input 7.
  function automatic logic [SEL_W-1:0] start_code(input logic dir_down);
    return dir_down ? SEL_W'(SCAN_LEN - 1) : '0;
  endfunction

endpackage

// File: rtl/mux8x1.sv
// Behavioural 8-to-1 select mux with active-high enable.
// Ports:
//   I[7:0]      data inputs
//   s2,s1,s0    select code, {s2,s1,s0} is the chosen input index
//   enable      output enable; Y is 0 while low
//   Y           selected data bit
module mux8x1 (
  input  logic [7:0] I,
  input  logic       s2,
  input  logic       s1,
  input  logic       s0,
  input  logic       enable,
  output logic       Y
);

  assign Y = enable & I[{s2, s1, s0}];

endmodule

// File: rtl/mux_scan_sequencer_scan_index_counter.sv
// Select register and step counter for one scan.
// The 3-bit select walks up or down modulo 8; the 4-bit step count tracks
// how many bits have been sampled so the FSM knows when the 8th lands.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   load        reset select to the start code and the step count to 0
//   advance     take one step (sample accepted this edge)
//   dir_down    0: select counts up, 1: select counts down
//   sel         current select code
//   last_step   the step being taken now is the final one of the scan
module scan_index_counter
  import mux_scan_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  input  logic             dir_down,
  output logic [SEL_W-1:0] sel,
  output logic             last_step
);

  logic [SEL_W-1:0]  sel_q,  sel_d;
  logic [STEP_W-1:0] step_q, step_d;

  always_comb begin
    // NOTE: every combinational output is given its hold value first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    sel_d  = sel_q;
    step_d = step_q;
    if (load) begin
      sel_d  = start_code(dir_down);
      step_d = '0;
    end else if (advance) begin
      // Eight steps return select to the start code without an explicit wrap.
      sel_d  = dir_down ? sel_q - 1'b1 : sel_q + 1'b1;
      step_d = step_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: flops take non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    if (rst) begin
      sel_q  <= start_code(dir_down);
      step_q <= '0;
    end else begin
      sel_q  <= sel_d;
      step_q <= step_d;
    end
  end

  assign sel       = sel_q;
  assign last_step = (step_q == STEP_W'(SCAN_LEN - 1));

endmodule

// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for an 8-to-1 mux: latches a word onto the mux inputs, walks
// the select through all eight codes with the mux enabled, samples the mux
// output back each step, rebuilds the word and flags any mismatching bit.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start, data_in  scan request and the word to scan (taken in IDLE only)
//   hold            stall during SCAN
//   y_in            mux output fed back
//   I               latched word to the mux data inputs
//   s2,s1,s0        select code to the mux
//   enable          mux enable, high during SCAN
//   busy            high outside IDLE
//   done            one-cycle pulse; out_word and mismatch valid
//   out_word        word reassembled from y_in
//   mismatch        sticky bit-disagreement flag for the last scan
module mux_scan_sequencer
  import mux_scan_sequencer_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       hold,
  input  logic       y_in,
  output logic [7:0] I,
  output logic       s2,
  output logic       s1,
  output logic       s0,
  output logic       enable,
  output logic       busy,
  output logic       done,
  output logic [7:0] out_word,
  output logic       mismatch
);

  logic [1:0]       state_q,    state_d;
  logic [7:0]       i_q,        i_d;
  logic [7:0]       out_word_q, out_word_d;
  logic             mismatch_q, mismatch_d;

  logic [SEL_W-1:0] sel;
  logic             last_step;
  logic             load;
  logic             advance;

  assign load    = (state_q == ST_IDLE) && start;
  assign advance = (state_q == ST_SCAN) && !hold;

  scan_index_counter u_index (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .advance   (advance),
    .dir_down  (MSB_FIRST),
    .sel       (sel),
    .last_step (last_step)
  );

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    out_word_d = out_word_q;
    mismatch_d = mismatch_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_SCAN;
          i_d        = data_in;
          out_word_d = '0;
          mismatch_d = 1'b0;
        end
      end
      ST_SCAN: begin
        if (!hold) begin
          // y_in reflects the select and enable driven during this cycle.
          out_word_d[sel] = y_in;
          if (y_in != i_q[sel]) mismatch_d = 1'b1;
          if (last_step) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      i_q        <= '0;
      out_word_q <= '0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      out_word_q <= out_word_d;
      mismatch_q <= mismatch_d;
    end
  end

  // Status outputs are pure decodes of the state register.
  assign enable       = (state_q == ST_SCAN);
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign I            = i_q;
  assign {s2, s1, s0} = sel;
  assign out_word     = out_word_q;
  assign mismatch     = mismatch_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Loopback bench: two sequencers (LSB-first and MSB-first) each drive a mux8x1
// whose output is fed back, optionally forced to 0 to inject faults.
module tb_mux_scan_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, hold, fz;
  logic [7:0] data_in;

  logic [7:0] i0, w0, i1, w1;
  logic       s2_0, s1_0, s0_0, en0, busy0, done0, mis0, muxy0, y0;
  logic       s2_1, s1_1, s0_1, en1, busy1, done1, mis1, muxy1, y1;

  assign y0 = fz ? 1'b0 : muxy0;
  assign y1 = fz ? 1'b0 : muxy1;

  mux_scan_sequencer #(.MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .hold(hold),
    .y_in(y0), .I(i0), .s2(s2_0), .s1(s1_0), .s0(s0_0), .enable(en0),
    .busy(busy0), .done(done0), .out_word(w0), .mismatch(mis0)
  );
  mux8x1 mux0 (.I(i0), .s2(s2_0), .s1(s1_0), .s0(s0_0), .enable(en0), .Y(muxy0));

  mux_scan_sequencer #(.MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .hold(hold),
    .y_in(y1), .I(i1), .s2(s2_1), .s1(s1_1), .s0(s0_1), .enable(en1),
    .busy(busy1), .done(done1), .out_word(w1), .mismatch(mis1)
  );
  mux8x1 mux1 (.I(i1), .s2(s2_1), .s1(s1_1), .s0(s0_1), .enable(en1), .Y(muxy1));

  // ---------------- checking ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h, expected 0x%02h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // pos: -1 idle, 0..7 = number of bits already sampled in this scan, 8 = done.
  typedef struct {
    int         pos;
    logic [7:0] i;
    logic [7:0] word;
    logic       mis;
  } model_t;

  model_t m0, m1;

  function automatic logic [2:0] msel(input model_t m, input bit msb);
    if (m.pos >= 0 && m.pos < 8) return msb ? 3'(7 - m.pos) : 3'(m.pos);
    return msb ? 3'd7 : 3'd0;
  endfunction

  function automatic logic my(input model_t m, input bit msb, input logic f);
    if (f || m.pos < 0 || m.pos >= 8) return 1'b0;
    return m.i[msel(m, msb)];
  endfunction

  function automatic model_t mstep(input model_t m, input bit msb, input logic r,
                                   input logic st, input logic [7:0] d,
                                   input logic h, input logic y);
    model_t     n;
    logic [2:0] b;
    n = m;
    if (r) begin
      n.pos = -1; n.i = '0; n.word = '0; n.mis = 1'b0;
    end else if (m.pos < 0) begin
      if (st) begin
        n.pos = 0; n.i = d; n.word = '0; n.mis = 1'b0;
      end
    end else if (m.pos >= 8) begin
      n.pos = -1;
    end else if (!h) begin
      b         = msel(m, msb);
      n.word[b] = y;
      if (y !== m.i[b]) n.mis = 1'b1;
      n.pos     = m.pos + 1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    logic ym0, ym1;
    ym0 = my(m0, 1'b0, fz);
    ym1 = my(m1, 1'b1, fz);
    m0  = mstep(m0, 1'b0, rst, start, data_in, hold, ym0);
    m1  = mstep(m1, 1'b1, rst, start, data_in, hold, ym1);
  end

  task automatic compare(input string t, input model_t m, input bit msb,
                         input logic [7:0] di, input logic [2:0] ds,
                         input logic den, input logic db, input logic dd,
                         input logic [7:0] dw, input logic dm);
    check({t, ".I"},        di,  m.i);
    check({t, ".sel"},      8'(ds), 8'(msel(m, msb)));
    check({t, ".enable"},   8'(den), 8'(m.pos >= 0 && m.pos < 8));
    check({t, ".busy"},     8'(db),  8'(m.pos >= 0));
    check({t, ".done"},     8'(dd),  8'(m.pos == 8));
    check({t, ".out_word"}, dw,  m.word);
    check({t, ".mismatch"}, 8'(dm), 8'(m.mis));
  endtask

  logic cmp_on = 1'b0;
  int   done_cnt0 = 0, done_cnt1 = 0;

  always @(negedge clk) begin
    if (cmp_on) begin
      compare("lsb", m0, 1'b0, i0, {s2_0, s1_0, s0_0}, en0, busy0, done0, w0, mis0);
      compare("msb", m1, 1'b1, i1, {s2_1, s1_1, s0_1}, en1, busy1, done1, w1, mis1);
      if (done0) done_cnt0++;
      if (done1) done_cnt1++;
    end
  end

  // ---------------- directed stimulus ----------------
  int         done_k0, done_k1;
  logic [7:0] w0_done, w1_done;
  logic       mis0_done, mis1_done;
  logic [2:0] sel0_log [0:31];
  logic [2:0] sel1_log [0:31];
  logic       busy0_log[0:31];
  logic       mis0_log [0:31];
  logic [7:0] i0_log   [0:31];
  logic [7:0] w0_log   [0:31];

  // Cycle k lies between edge k-1 and edge k; start is taken at edge 0.
  // Controls set at the negedge of cycle k are sampled at edge k.
  task automatic run_scan(input logic [7:0] d, input int hold_lo, input int hold_hi,
                          input int bs_k, input int rst_k, input logic f,
                          input int max_k);
    @(negedge clk);
    start = 1'b1; data_in = d; fz = f;
    done_k0 = 0; done_k1 = 0;
    for (int k = 1; k <= max_k; k++) begin
      @(negedge clk);
      sel0_log[k]  = {s2_0, s1_0, s0_0};
      sel1_log[k]  = {s2_1, s1_1, s0_1};
      busy0_log[k] = busy0;
      mis0_log[k]  = mis0;
      i0_log[k]    = i0;
      w0_log[k]    = w0;
      if (done0 && done_k0 == 0) begin done_k0 = k; w0_done = w0; mis0_done = mis0; end
      if (done1 && done_k1 == 0) begin done_k1 = k; w1_done = w1; mis1_done = mis1; end
      hold    = (k >= hold_lo && k <= hold_hi);
      start   = (k == bs_k);
      data_in = (k == bs_k) ? 8'h11 : d;
      rst     = (k == rst_k);
      if (done_k0 != 0 && done_k1 != 0) break;
    end
    hold = 1'b0; start = 1'b0; rst = 1'b0; fz = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hold = 1'b0; fz = 1'b0; data_in = 8'h00;
    m0 = '{pos: -1, i: 8'h00, word: 8'h00, mis: 1'b0};
    m1 = m0;
    repeat (2) @(negedge clk);
    cmp_on = 1'b1;
    check("rst.I",        i0, 8'h00);
    check("rst.sel_lsb",  8'({s2_0, s1_0, s0_0}), 8'd0);
    check("rst.sel_msb",  8'({s2_1, s1_1, s0_1}), 8'd7);
    check("rst.busy",     8'(busy0), 8'd0);
    check("rst.enable",   8'(en0),   8'd0);
    check("rst.done",     8'(done0), 8'd0);
    check("rst.out_word", w0, 8'h00);
    check("rst.mismatch", 8'(mis0), 8'd0);
    rst = 1'b0;

    // Basic scan, both directions observed.
    run_scan(8'hA5, 0, -1, 0, 0, 1'b0, 20);
    check("basic.done_cycle", 8'(done_k0), 8'd9);
    check("basic.out_word",   w0_done, 8'hA5);
    check("basic.mismatch",   8'(mis0_done), 8'd0);
    for (int k = 1; k <= 8; k++) check("basic.sel", 8'(sel0_log[k]), 8'(k - 1));

    // MSB-first scan.
    run_scan(8'h3C, 0, -1, 0, 0, 1'b0, 20);
    check("msb.done_cycle", 8'(done_k1), 8'd9);
    check("msb.out_word",   w1_done, 8'h3C);
    for (int k = 1; k <= 8; k++) check("msb.sel", 8'(sel1_log[k]), 8'(8 - k));

    // Hold in cycles 3-4.
    run_scan(8'h5A, 3, 4, 0, 0, 1'b0, 20);
    check("hold.sel_c3",    8'(sel0_log[3]), 8'd2);
    check("hold.sel_c4",    8'(sel0_log[4]), 8'd2);
    check("hold.sel_c5",    8'(sel0_log[5]), 8'd2);
    check("hold.sel_c6",    8'(sel0_log[6]), 8'd3);
    check("hold.done_cycle", 8'(done_k0), 8'd11);
    check("hold.out_word",  w0_done, 8'h5A);

    // Fault injection: loopback forced to 0.
    run_scan(8'hFF, 0, -1, 0, 0, 1'b1, 20);
    check("fault.out_word", w0_done, 8'h00);
    check("fault.mismatch", 8'(mis0_done), 8'd1);
    check("fault.out_msb",  w1_done, 8'h00);
    check("fault.mis_msb",  8'(mis1_done), 8'd1);

    // Start pulsed mid-scan with another word.
    run_scan(8'hA5, 0, -1, 4, 0, 1'b0, 20);
    check("busy.mis_cleared", 8'(mis0_log[1]), 8'd0);
    check("busy.I_kept",      i0_log[5], 8'hA5);
    check("busy.done_cycle",  8'(done_k0), 8'd9);
    check("busy.out_word",    w0_done, 8'hA5);

    // Reset in cycle 5 aborts the scan.
    run_scan(8'hA5, 0, -1, 0, 5, 1'b0, 12);
    check("rstmid.busy",     8'(busy0_log[6]), 8'd0);
    check("rstmid.I",        i0_log[6], 8'h00);
    check("rstmid.out_word", w0_log[6], 8'h00);
    check("rstmid.sel_lsb",  8'(sel0_log[6]), 8'd0);
    check("rstmid.sel_msb",  8'(sel1_log[6]), 8'd7);
    check("rstmid.no_done",  8'(done_k0), 8'd0);
    run_scan(8'hC3, 0, -1, 0, 0, 1'b0, 20);
    check("after_rst.done_cycle", 8'(done_k0), 8'd9);
    check("after_rst.out_word",   w0_done, 8'hC3);

    repeat (3) @(negedge clk);
    check("done_pulses_lsb", 8'(done_cnt0), 8'd6);
    check("done_pulses_msb", 8'(done_cnt1), 8'd6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mux_scan_sequencer.md
# mux_scan_sequencer

Sequential driver and checker for the 8-to-1 select mux stage. It latches an 8-bit word and drives it onto the mux data inputs. It then steps the select lines `s2,s1,s0` through all eight codes, one per clock, with the mux enabled. The mux output `Y` is sampled back each step, so the block reassembles the word and flags any bit that disagrees with what was driven. Together with the mux, it forms a parallel-to-serial scan path with loopback self-check.

## Interface

Parameters:
- `MSB_FIRST`, default 0: scan order. 0 steps select 0→7; 1 steps select 7→0.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request a scan; honoured only in IDLE.
- `data_in`  in  8  word to scan; captured on the accepted `start`.
- `hold`  in  1  stall; in SCAN, freezes select, sampling and step count.
- `y_in`  in  1  mux output `Y`, fed back.
- `I`  out  8  latched word, drives mux `I[7:0]`.
- `s2`, `s1`, `s0`  out  1 each  select code to the mux; `{s2,s1,s0}` is the bit index.
- `enable`  out  1  mux enable.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse; `out_word` and `mismatch` are valid on it.
- `out_word`  out  8  word reassembled from `y_in`.
- `mismatch`  out  1  sticky; at least one sampled bit differed from the driven bit.

## Operation

- The FSM has three states: IDLE, SCAN and DONE.
- IDLE:
  - `enable`=0, `busy`=0, `done`=0; select held at the start code.
  - If `start`=1: `I`←`data_in`, `out_word`←0, `mismatch`←0, step count←0, select←start code, go to SCAN.
  - The start code is 0 when `MSB_FIRST`=0 and 7 when `MSB_FIRST`=1.
- SCAN:
  - `enable`=1 and `busy`=1.
  - On each edge with `hold`=0:
    - `out_word[sel]`←`y_in`.
    - If `y_in` ≠ `I[sel]`, set `mismatch`.
    - Increment the step count.
    - Advance select by +1 (`MSB_FIRST`=0) or −1 (`MSB_FIRST`=1), modulo 8.
  - When the step being sampled is the 8th, go to DONE. Select wraps back to the start code.
  - `hold`=1: no change to any state; `enable` stays 1.
- DONE:
  - `done`=1, `enable`=0, `busy`=1 for exactly one cycle, then IDLE.
  - `hold` is ignored.
- `start` outside IDLE is ignored and is not queued.
- `I`, `out_word` and `mismatch` keep their values in IDLE until the next accepted `start`.
- Step count width is 4 bits (0..8). Select is a 3-bit register wrapping modulo 8.

## Timing

- Reset, taking priority over everything:
  - state=IDLE, `I`=0x00, select=start code, `enable`=0, `busy`=0, `done`=0, `out_word`=0x00, `mismatch`=0.
  - Reset mid-SCAN or in DONE aborts with no `done` pulse.
- Latency, with `start` accepted at edge 0 and no holds:
  - SCAN occupies cycles 1–8.
  - The select during cycle k is the start code ±(k−1).
  - `done`=1 in cycle 9; IDLE from cycle 10.
  - A new `start` is accepted at edge 10 at the earliest. Back-to-back throughput is one word per 10 cycles.
- Each `hold`=1 cycle in SCAN adds one cycle to the latency.
- `y_in` is combinational from the mux. It is sampled at the end of the cycle in which the matching select and `enable` are driven.
- All outputs are registered or decoded from the state register. There is no combinational path from inputs to outputs.

## Structure

- Shared package holds:
  - the state encoding constants `ST_IDLE`=2'd0, `ST_SCAN`=2'd1, `ST_DONE`=2'd2;
  - `SCAN_LEN`=8;
  - `SEL_W`=3.
- Sub-module `scan_index_counter`: the 3-bit up/down select register plus the 4-bit step count. Inputs are load, advance and direction; output is `last_step`.
- The FSM, capture and compare logic live in the top module.
- The bench instantiates the existing `mux8x1` between `I/s*/enable` and `y_in` for loopback.

## Test plan

- Basic scan: `MSB_FIRST`=0, `data_in`=0xA5, `start` at edge 0, no holds.
  - Select runs 0..7 in cycles 1–8; `done` in cycle 9.
  - `out_word`=0xA5, `mismatch`=0.
- MSB-first scan: `MSB_FIRST`=1, `data_in`=0x3C.
  - Select runs 7..0.
  - `out_word`=0x3C, `done` in cycle 9.
- Hold stall: 0x5A with `hold`=1 in cycles 3–4.
  - Select stays 2 across cycles 3–5.
  - `done` in cycle 11; `out_word`=0x5A.
- Fault injection: `data_in`=0xFF with `y_in` forced 0 instead of the mux output.
  - `out_word`=0x00, `mismatch`=1 at `done`.
  - The next accepted `start` clears `mismatch` to 0.
- Start while busy: `start` pulsed with 0x11 in cycle 4 of a 0xA5 scan.
  - Ignored; `out_word`=0xA5; no extra `done`.
- Reset mid-scan: `rst`=1 in cycle 5.
  - Next cycle: IDLE with all outputs at reset values; no `done`.
  - A following `start` with 0xC3 completes with `out_word`=0xC3.
